// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC 16-bit CPU front end.
// Contents: datapath widths, opcode encodings, immediate-kind encodings,
// the pipeline bubble instruction and the IF/ID halt FSM state encodings.
package wisc_pkg;

  localparam int unsigned WISC_INSTR_W = 16;
  localparam int unsigned WISC_PC_W    = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_RED  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_ROR  = 4'b0110;
  localparam logic [3:0] OP_PADD = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LLB  = 4'b1010;
  localparam logic [3:0] OP_LHB  = 4'b1011;
  localparam logic [3:0] OP_B    = 4'b1100;
  localparam logic [3:0] OP_BR   = 4'b1101;
  localparam logic [3:0] OP_PCS  = 4'b1110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  // Kind tells the ID-stage extender which bit is the sign bit (3/7/8).
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM4     = 2'd1,
    IMM8     = 2'd2,
    IMM9     = 2'd3
  } imm_kind_e;

  // ADD $0,$0,$0: writes the zero register, so it is architecturally inert.
  localparam logic [WISC_INSTR_W-1:0] BUBBLE_INSTR = 16'h0000;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } halt_state_e;

endpackage

// File: rtl/if_id_stage_reg_if.sv
// IF/ID boundary bundle.
// master: fetch unit + hazard unit side (drives if_*, stall, flush; observes id_*).
// slave : the IF/ID stage register (consumes if_*, stall, flush; drives id_*).
interface if_id_stage_reg_if;
  import wisc_pkg::*;

  logic                    if_valid;
  logic [WISC_INSTR_W-1:0] if_instr;
  logic [WISC_PC_W-1:0]    if_pc_next;
  logic                    stall;
  logic                    flush;

  logic                    id_valid;
  logic [WISC_INSTR_W-1:0] id_instr;
  logic [WISC_PC_W-1:0]    id_pc_next;
  logic [3:0]              id_opcode;
  logic [3:0]              id_rd;
  logic [3:0]              id_rs;
  logic [3:0]              id_rt;
  logic [2:0]              id_cond;
  logic [15:0]             id_imm_field;
  logic [1:0]              id_imm_kind;
  logic                    id_halt;

  modport master (
    output if_valid, if_instr, if_pc_next, stall, flush,
    input  id_valid, id_instr, id_pc_next, id_opcode, id_rd, id_rs, id_rt, id_cond,
           id_imm_field, id_imm_kind, id_halt
  );

  modport slave (
    input  if_valid, if_instr, if_pc_next, stall, flush,
    output id_valid, id_instr, id_pc_next, id_opcode, id_rd, id_rs, id_rt, id_cond,
           id_imm_field, id_imm_kind, id_halt
  );

endinterface

// File: rtl/imm_field_extract.sv
// Combinational immediate extractor.
// Ports: instr     (in, 16)  instruction word
//        imm_field (out, 16) immediate bits right-justified, upper bits zero
//        imm_kind  (out, 2)  IMM_NONE / IMM4 / IMM8 / IMM9
// No extension or scaling is done here; the ID stage does that from imm_kind.
module imm_field_extract
  import wisc_pkg::*;
(
  input  logic [15:0] instr,
  output logic [15:0] imm_field,
  output imm_kind_e   imm_kind
);

  always_comb begin
    imm_field = 16'h0000;
    imm_kind  = IMM_NONE;
    unique case (instr[15:12])
      OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW: begin
        imm_field = {12'h000, instr[3:0]};
        imm_kind  = IMM4;
      end
      OP_LLB, OP_LHB: begin
        imm_field = {8'h00, instr[7:0]};
        imm_kind  = IMM8;
      end
      OP_B: begin
        imm_field = {7'h00, instr[8:0]};
        imm_kind  = IMM9;
      end
      default: begin
        imm_field = 16'h0000;
        imm_kind  = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register for the WISC 16-bit CPU.
// Captures the fetched instruction, PC+2 and a pre-decoded field set
// (opcode, rd/rs/rt, branch condition, right-justified immediate and its kind).
// Ports: clk   (in)  rising-edge clock
//        rst_n (in)  synchronous active-low reset
//        bus   (if_id_stage_reg_if.slave) if_valid/if_instr/if_pc_next/stall/flush in,
//              id_* pipeline outputs out
// Edge priority: reset > flush > stall > load.
// Optional feature: define WISC_HALT_DETECT_EN to enable HLT capture (RUN/HALTED FSM);
// otherwise id_halt is tied low and HLT is handled like any other opcode.
module if_id_stage_reg
  import wisc_pkg::*;
#(
  parameter int unsigned          INSTR_W = WISC_INSTR_W,
  parameter int unsigned          PC_W    = WISC_PC_W,
  parameter logic [INSTR_W-1:0]   BUBBLE  = BUBBLE_INSTR
) (
  input logic               clk,
  input logic               rst_n,
  if_id_stage_reg_if.slave  bus
);

  logic [INSTR_W-1:0] src_instr;
  logic [3:0]         dec_rs;
  logic [3:0]         dec_rt;
  logic [15:0]        dec_imm_field;
  imm_kind_e          dec_imm_kind;
  logic               hold;

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic [3:0]         opcode_q;
  logic [3:0]         rd_q;
  logic [3:0]         rs_q;
  logic [3:0]         rt_q;
  logic [2:0]         cond_q;
  logic [15:0]        imm_field_q;
  logic [1:0]         imm_kind_q;

  // Whatever instruction this edge will capture: the bubble on flush or an
  // invalid fetch, otherwise the fetched word. Decode always follows it.
  always_comb begin
    src_instr = bus.if_instr;
    if (bus.flush || !bus.if_valid) begin
      src_instr = BUBBLE;
    end
  end

  always_comb begin
    dec_rs = src_instr[7:4];
    dec_rt = src_instr[3:0];
    if (src_instr[15:12] == OP_LLB || src_instr[15:12] == OP_LHB) begin
      dec_rs = src_instr[11:8];
    end
    // SW reads its data register through the rt port.
    if (src_instr[15:12] == OP_SW) begin
      dec_rt = src_instr[11:8];
    end
  end

  imm_field_extract u_imm_field_extract (
    .instr     (src_instr),
    .imm_field (dec_imm_field),
    .imm_kind  (dec_imm_kind)
  );

`ifdef WISC_HALT_DETECT_EN
  halt_state_e state_q;
  logic        halt_q;

  // Once halted, HLT must stay in ID until a flush squashes it.
  assign hold = bus.stall || (state_q == StHalted);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      halt_q  <= 1'b0;
    end else if (bus.flush) begin
      state_q <= StRun;
      halt_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (!bus.stall && bus.if_valid && bus.if_instr[15:12] == OP_HLT) begin
            state_q <= StHalted;
            halt_q  <= 1'b1;
          end
        end
        StHalted: begin
          state_q <= StHalted;
          halt_q  <= 1'b1;
        end
        default: begin
          state_q <= StRun;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.id_halt = halt_q;
`else
  assign hold        = bus.stall;
  assign bus.id_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      instr_q     <= BUBBLE;
      pc_q        <= '0;
      opcode_q    <= 4'h0;
      rd_q        <= 4'h0;
      rs_q        <= 4'h0;
      rt_q        <= 4'h0;
      cond_q      <= 3'h0;
      imm_field_q <= 16'h0000;
      imm_kind_q  <= IMM_NONE;
    end else if (bus.flush || !hold) begin
      // Flush and load share the path; src_instr already selects the bubble.
      valid_q     <= bus.flush ? 1'b0 : bus.if_valid;
      instr_q     <= src_instr;
      pc_q        <= bus.flush ? '0 : bus.if_pc_next;
      opcode_q    <= src_instr[15:12];
      rd_q        <= src_instr[11:8];
      rs_q        <= dec_rs;
      rt_q        <= dec_rt;
      cond_q      <= src_instr[11:9];
      imm_field_q <= dec_imm_field;
      imm_kind_q  <= dec_imm_kind;
    end
  end

  assign bus.id_valid     = valid_q;
  assign bus.id_instr     = instr_q;
  assign bus.id_pc_next   = pc_q;
  assign bus.id_opcode    = opcode_q;
  assign bus.id_rd        = rd_q;
  assign bus.id_rs        = rs_q;
  assign bus.id_rt        = rt_q;
  assign bus.id_cond      = cond_q;
  assign bus.id_imm_field = imm_field_q;
  assign bus.id_imm_kind  = imm_kind_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: directed scenarios plus a randomized
// run checked against a behavioural model of the IF/ID register.
// Honours WISC_HALT_DETECT_EN the same way the design does.
module tb_if_id_stage_reg;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  if_id_stage_reg_if bus ();

  if_id_stage_reg u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what ID should hold after the most recent edge.
  logic        m_valid;
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic        m_halted;

  // Expected decode as {opcode, rd, rs, rt, cond, imm_field, imm_kind}.
  function automatic logic [40:0] ref_decode(input logic [15:0] w);
    int op, rd, rs, rt, cond, imm, kind;
    op   = int'(w) / 4096;
    rd   = (int'(w) / 256) % 16;
    rs   = (int'(w) / 16) % 16;
    rt   = int'(w) % 16;
    cond = (int'(w) / 512) % 8;
    imm  = 0;
    kind = 0;
    if (op == 10 || op == 11) rs = rd;
    if (op == 9) rt = rd;
    if ((op >= 4 && op <= 6) || op == 8 || op == 9) begin
      imm = int'(w) % 16; kind = 1;
    end else if (op == 10 || op == 11) begin
      imm = int'(w) % 256; kind = 2;
    end else if (op == 12) begin
      imm = int'(w) % 512; kind = 3;
    end
    return {op[3:0], rd[3:0], rs[3:0], rt[3:0], cond[2:0], imm[15:0], kind[1:0]};
  endfunction

  // Advance the model using the inputs currently applied, then take the edge.
  task automatic tick();
    if (!rst_n) begin
      m_valid = 1'b0; m_instr = 16'h0000; m_pc = 16'h0000; m_halted = 1'b0;
    end else if (bus.flush) begin
      m_valid = 1'b0; m_instr = 16'h0000; m_pc = 16'h0000; m_halted = 1'b0;
    end else if (!bus.stall && !m_halted) begin
      m_valid = bus.if_valid;
      m_instr = bus.if_valid ? bus.if_instr : 16'h0000;
      m_pc    = bus.if_pc_next;
`ifdef WISC_HALT_DETECT_EN
      m_halted = bus.if_valid && (bus.if_instr >= 16'hF000);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] pc,
                       input logic st, input logic fl);
    bus.if_valid = v; bus.if_instr = i; bus.if_pc_next = pc; bus.stall = st; bus.flush = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 16'h8123, 16'h0042, 1'b0, 1'b0);
    tick();
    tick();
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid got %b exp 0", bus.id_valid); end
    n_cmp++; if (bus.id_instr !== 16'h0000) begin n_fail++;
      $display("FAIL reset_instr got %h exp 0000", bus.id_instr); end
    n_cmp++; if (bus.id_pc_next !== 16'h0000) begin n_fail++;
      $display("FAIL reset_pc got %h exp 0000", bus.id_pc_next); end
    n_cmp++; if ({bus.id_opcode, bus.id_rd, bus.id_rs, bus.id_rt, bus.id_cond,
                  bus.id_imm_field, bus.id_imm_kind} !== 41'h0) begin n_fail++;
      $display("FAIL reset_decode got nonzero decode %h", bus.id_imm_field); end
    n_cmp++; if (bus.id_halt !== 1'b0) begin n_fail++;
      $display("FAIL reset_halt got %b exp 0", bus.id_halt); end
  endtask

  task automatic test_lw();
    rst_n = 1'b1;
    drive(1'b1, 16'h8123, 16'h0042, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.id_valid !== 1'b1) begin n_fail++;
      $display("FAIL lw_valid got %b exp 1", bus.id_valid); end
    n_cmp++; if (bus.id_opcode !== 4'h8) begin n_fail++;
      $display("FAIL lw_opcode got %h exp 8", bus.id_opcode); end
    n_cmp++; if ({bus.id_rd, bus.id_rs, bus.id_rt} !== 12'h123) begin n_fail++;
      $display("FAIL lw_regs got %h exp 123", {bus.id_rd, bus.id_rs, bus.id_rt}); end
    n_cmp++; if (bus.id_imm_field !== 16'h0003 || bus.id_imm_kind !== 2'd1) begin n_fail++;
      $display("FAIL lw_imm got %h/%0d exp 0003/1", bus.id_imm_field, bus.id_imm_kind); end
    n_cmp++; if (bus.id_pc_next !== 16'h0042) begin n_fail++;
      $display("FAIL lw_pc got %h exp 0042", bus.id_pc_next); end
  endtask

  task automatic test_decode();
    drive(1'b1, 16'hC5FF, 16'h0100, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.id_cond !== 3'd2) begin n_fail++;
      $display("FAIL b_cond got %0d exp 2", bus.id_cond); end
    n_cmp++; if (bus.id_imm_field !== 16'h01FF || bus.id_imm_kind !== 2'd3) begin n_fail++;
      $display("FAIL b_imm got %h/%0d exp 01FF/3", bus.id_imm_field, bus.id_imm_kind); end
    drive(1'b1, 16'hA7AB, 16'h0102, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.id_rs !== 4'd7) begin n_fail++;
      $display("FAIL llb_rs got %0d exp 7", bus.id_rs); end
    n_cmp++; if (bus.id_imm_field !== 16'h00AB || bus.id_imm_kind !== 2'd2) begin n_fail++;
      $display("FAIL llb_imm got %h/%0d exp 00AB/2", bus.id_imm_field, bus.id_imm_kind); end
    drive(1'b1, 16'h9456, 16'h0104, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.id_rt !== 4'd4) begin n_fail++;
      $display("FAIL sw_rt got %0d exp 4", bus.id_rt); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 16'h1234, 16'h0200, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h2000 + 16'(k), 16'h0300, 1'b1, 1'b0);
      tick();
      n_cmp++; if (bus.id_instr !== 16'h1234 || bus.id_valid !== 1'b1) begin n_fail++;
        $display("FAIL stall_hold got %h/%b exp 1234/1", bus.id_instr, bus.id_valid); end
    end
    drive(1'b1, 16'h3333, 16'h0400, 1'b1, 1'b1);
    tick();
    n_cmp++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 16'h0000) begin n_fail++;
      $display("FAIL stall_flush got %b/%h exp 0/0000", bus.id_valid, bus.id_instr); end
    n_cmp++; if (bus.id_pc_next !== 16'h0000) begin n_fail++;
      $display("FAIL flush_pc got %h exp 0000", bus.id_pc_next); end
  endtask

  task automatic test_halt();
    drive(1'b1, 16'hF000, 16'h0500, 1'b0, 1'b0);
    tick();
`ifdef WISC_HALT_DETECT_EN
    n_cmp++; if (bus.id_halt !== 1'b1) begin n_fail++;
      $display("FAIL halt_set got %b exp 1", bus.id_halt); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'h0123, 16'h0502, 1'(k), 1'b0);
      tick();
      n_cmp++; if (bus.id_instr !== 16'hF000 || bus.id_valid !== 1'b1) begin n_fail++;
        $display("FAIL halt_hold got %h/%b exp F000/1", bus.id_instr, bus.id_valid); end
    end
    drive(1'b1, 16'h0123, 16'h0502, 1'b0, 1'b1);
    tick();
    n_cmp++; if (bus.id_halt !== 1'b0 || bus.id_instr !== 16'h0000) begin n_fail++;
      $display("FAIL halt_flush got %b/%h exp 0/0000", bus.id_halt, bus.id_instr); end
`else
    n_cmp++; if (bus.id_instr !== 16'hF000 || bus.id_halt !== 1'b0) begin n_fail++;
      $display("FAIL hlt_plain got %h/%b exp F000/0", bus.id_instr, bus.id_halt); end
    drive(1'b1, 16'h0123, 16'h0502, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.id_instr !== 16'h0123 || bus.id_halt !== 1'b0) begin n_fail++;
      $display("FAIL hlt_next got %h/%b exp 0123/0", bus.id_instr, bus.id_halt); end
`endif
  endtask

  task automatic test_midrun_reset();
    drive(1'b1, 16'h5321, 16'h0600, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h7777, 16'h0602, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.id_instr !== 16'h5321) begin n_fail++;
      $display("FAIL mid_stall got %h exp 5321", bus.id_instr); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 16'h0000 ||
                 bus.id_pc_next !== 16'h0000 || bus.id_opcode !== 4'h0 ||
                 bus.id_imm_field !== 16'h0000) begin n_fail++;
      $display("FAIL mid_reset got v=%b i=%h pc=%h op=%h", bus.id_valid, bus.id_instr,
               bus.id_pc_next, bus.id_opcode); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] w;
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 99) >= 3);
      w = 16'($urandom);
      if ($urandom_range(0, 9) == 0) w[15:12] = 4'hF;
      drive(1'($urandom_range(0, 4) != 0), w, 16'($urandom),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
      tick();
      n_cmp++; if (bus.id_valid !== m_valid || bus.id_instr !== m_instr ||
                   bus.id_pc_next !== m_pc) begin n_fail++;
        $display("FAIL rand_regs cyc %0d got %b/%h/%h exp %b/%h/%h", k, bus.id_valid,
                 bus.id_instr, bus.id_pc_next, m_valid, m_instr, m_pc); end
      n_cmp++; if ({bus.id_opcode, bus.id_rd, bus.id_rs, bus.id_rt, bus.id_cond,
                    bus.id_imm_field, bus.id_imm_kind} !== ref_decode(m_instr)) begin n_fail++;
        $display("FAIL rand_decode cyc %0d instr %h got %h exp %h", k, m_instr,
                 {bus.id_opcode, bus.id_rd, bus.id_rs, bus.id_rt, bus.id_cond,
                  bus.id_imm_field, bus.id_imm_kind}, ref_decode(m_instr)); end
      n_cmp++; if (bus.id_halt !== m_halted) begin n_fail++;
        $display("FAIL rand_halt cyc %0d got %b exp %b", k, bus.id_halt, m_halted); end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    m_instr  = 16'h0000;
    m_pc     = 16'h0000;
    m_halted = 1'b0;
    rst_n    = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #2;
    test_reset();
    test_lw();
    test_decode();
    test_stall_flush();
    test_halt();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
